// File: rtl/psi_src_arbiter.sv
// Round-robin arbiter sharing one parallel-to-serial input port among nreq word producers.
// Latches the winner's word, holds psi_req until granted, acks the winner, aborts on wait timeout or flush.
module psi_src_arbiter #(
  parameter int datasize = 32,
  parameter int nreq     = 4,
  parameter int idxw     = 2,
  parameter int maxwait  = 255,
  parameter int cntw     = 16
) (
  input  logic                     p_clk,
  input  logic                     n_rst,
  input  logic [nreq-1:0]          src_req,
  input  logic [nreq*datasize-1:0] src_data,
  output logic [nreq-1:0]          src_ack,
  output logic                     psi_req,
  output logic [datasize-1:0]      psi_data,
  input  logic                     psi_grant,
  input  logic                     fifo_full,
  input  logic                     flush,
  output logic [idxw-1:0]          owner,
  output logic                     busy,
  output logic                     timeout,
  output logic [cntw-1:0]          word_count
);

  localparam int waitw = (maxwait > 1) ? $clog2(maxwait) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t               state, state_d;
  logic [idxw-1:0]      last, last_d;
  logic [idxw-1:0]      owner_d, winner;
  logic                 found;
  logic [waitw-1:0]     wait_cnt, wait_cnt_d;
  logic                 psi_req_d, timeout_d, busy_d;
  logic [datasize-1:0]  psi_data_d;
  logic [nreq-1:0]      src_ack_d;
  logic [cntw-1:0]      word_count_d;
  int                   idx;

  // Rotating-priority search: start just after the last winner and wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 1; off <= nreq; off++) begin
      idx = (int'(last) + off) % nreq;
      if (!found && src_req[idx]) begin
        found  = 1'b1;
        winner = idxw'(idx);
      end
    end
  end

  // NOTE: every signal gets its hold/default value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d      = state;
    last_d       = last;
    owner_d      = owner;
    wait_cnt_d   = wait_cnt;
    psi_req_d    = psi_req;
    psi_data_d   = psi_data;
    src_ack_d    = '0;
    timeout_d    = 1'b0;
    word_count_d = word_count;

    case (state)
      IDLE: begin
        if (found && !fifo_full && !flush) begin
          owner_d    = winner;
          psi_data_d = src_data[winner*datasize +: datasize];
          psi_req_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // Grant wins over flush and over the wait limit on the same edge.
        if (psi_grant) begin
          psi_req_d    = 1'b0;
          src_ack_d    = {{(nreq-1){1'b0}}, 1'b1} << owner;
          last_d       = owner;
          word_count_d = word_count + 1'b1;
          state_d      = ACK;
        end else if (flush) begin
          psi_req_d = 1'b0;
          last_d    = owner;
          state_d   = IDLE;
        end else if (wait_cnt == waitw'(maxwait - 1)) begin
          psi_req_d = 1'b0;
          timeout_d = 1'b1;
          last_d    = owner;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge p_clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge p_clk or negedge n_rst) begin
    if (!n_rst) begin
      last       <= idxw'(nreq - 1);
      owner      <= '0;
      wait_cnt   <= '0;
      psi_req    <= 1'b0;
      psi_data   <= '0;
      src_ack    <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
    end else begin
      last       <= last_d;
      owner      <= owner_d;
      wait_cnt   <= wait_cnt_d;
      psi_req    <= psi_req_d;
      psi_data   <= psi_data_d;
      src_ack    <= src_ack_d;
      timeout    <= timeout_d;
      busy       <= busy_d;
      word_count <= word_count_d;
    end
  end

endmodule

// File: tb/tb_psi_src_arbiter.sv
// Self-checking bench for psi_src_arbiter: directed phases plus random traffic against a
// transaction-level model (rotating priority pointer and a word counter).
module tb_psi_src_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int MW = 4;
  localparam int CW = 3;

  logic             p_clk = 1'b0;
  logic             n_rst;
  logic [NR-1:0]    src_req;
  logic [NR*DW-1:0] src_data;
  logic [NR-1:0]    src_ack;
  logic             psi_req;
  logic [DW-1:0]    psi_data;
  logic             psi_grant, fifo_full, flush;
  logic [IW-1:0]    owner;
  logic             busy, timeout;
  logic [CW-1:0]    word_count;

  psi_src_arbiter #(.datasize(DW), .nreq(NR), .idxw(IW), .maxwait(MW), .cntw(CW)) dut (
    .p_clk(p_clk), .n_rst(n_rst), .src_req(src_req), .src_data(src_data), .src_ack(src_ack),
    .psi_req(psi_req), .psi_data(psi_data), .psi_grant(psi_grant), .fifo_full(fifo_full),
    .flush(flush), .owner(owner), .busy(busy), .timeout(timeout), .word_count(word_count)
  );

  always #5 p_clk = ~p_clk;

  int total = 0;
  int bad   = 0;
  int last_m;
  int wc_m;
  logic [DW-1:0] words [NR];

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r);
    for (int off = 1; off <= NR; off++)
      if (r[(last_m + off) % NR]) return (last_m + off) % NR;
    return -1;
  endfunction

  task automatic drive_words();
    for (int i = 0; i < NR; i++) src_data[i*DW +: DW] = words[i];
  endtask

  // Present requests, wait (bounded) for the arbitration, then have the winner change its word.
  task automatic arb(input logic [NR-1:0] r, output int w, output logic [DW-1:0] d, output int lat);
    int n;
    src_req = r;
    w = pick(r);
    d = words[w];
    n = 0;
    while (!psi_req && n < 30) begin
      tick();
      n++;
    end
    lat = n;
    check("arb_req", psi_req, 1);
    check("arb_owner", owner, w);
    check("arb_data", psi_data, d);
    check("arb_busy", busy, 1);
    words[w] = $urandom;
    drive_words();
  endtask

  task automatic grant_word(input int w, input logic [DW-1:0] d, input int gdly);
    for (int i = 0; i < gdly; i++) begin
      tick();
      check("hold_req", psi_req, 1);
    end
    check("frozen_data", psi_data, d);
    psi_grant = 1'b1;
    tick();
    psi_grant = 1'b0;
    wc_m   = (wc_m + 1) % (1 << CW);
    last_m = w;
    check("ack_pulse", src_ack, 1 << w);
    check("req_drop", psi_req, 0);
    check("word_count", word_count, wc_m);
    check("no_timeout", timeout, 0);
    tick();
    check("ack_clear", src_ack, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int w, lat, n;
    logic [DW-1:0] d;
    logic [NR-1:0] r;

    n_rst = 1'b0;
    src_req = '0;
    psi_grant = 1'b0;
    fifo_full = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NR; i++) words[i] = $urandom;
    drive_words();
    last_m = NR - 1;
    wc_m = 0;
    #12;
    check("rst_psi_req", psi_req, 0);
    check("rst_psi_data", psi_data, 0);
    check("rst_src_ack", src_ack, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_word_count", word_count, 0);
    n_rst = 1'b1;
    tick();

    // Two requesters held, immediate grants: owners alternate 0,2,0,2.
    for (int k = 0; k < 4; k++) begin
      arb(4'b0101, w, d, lat);
      check("alt_owner", w, (k % 2) * 2);
      grant_word(w, d, 0);
    end
    check("alt_count", word_count, 4);

    // All four held, grant one cycle later: every word re-arbitrates on the next edge.
    for (int k = 0; k < 5; k++) begin
      arb(4'b1111, w, d, lat);
      if (k > 0) check("rr_latency", lat, 1);
      grant_word(w, d, 1);
    end

    // FIFO full withholds arbitration; falling edge of full arbitrates next edge.
    src_req = '0;
    fifo_full = 1'b1;
    tick();
    src_req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("full_hold", psi_req, 0);
    end
    fifo_full = 1'b0;
    arb(4'b0010, w, d, lat);
    check("full_release_lat", lat, 1);
    check("full_owner", owner, 1);
    // Full rising during REQ does not abort; grant on the last allowed cycle still counts.
    fifo_full = 1'b1;
    grant_word(w, d, MW - 1);
    fifo_full = 1'b0;

    // Timeout: no grant for MW cycles.
    arb(4'b1111, w, d, lat);
    n = 0;
    while (psi_req && n < 20) begin
      check("to_quiet", timeout | (|src_ack), 0);
      n++;
      tick();
    end
    check("to_len", n, MW);
    check("to_pulse", timeout, 1);
    check("to_noack", src_ack, 0);
    check("to_count", word_count, wc_m);
    last_m = w;
    src_req = '0;
    tick();
    check("to_once", timeout, 0);
    check("to_idle", busy, 0);
    arb(4'b1111, n, d, lat);
    check("to_next", n, (w + 1) % NR);
    grant_word(n, d, 0);

    // Flush during REQ aborts silently and blocks arbitration while high.
    arb(4'b1011, w, d, lat);
    flush = 1'b1;
    tick();
    check("fl_drop", psi_req, 0);
    check("fl_noack", src_ack, 0);
    check("fl_notimeout", timeout, 0);
    last_m = w;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fl_hold", psi_req, 0);
    end
    flush = 1'b0;
    arb(4'b1011, w, d, lat);
    grant_word(w, d, 2);

    // Asynchronous reset while in REQ.
    arb(4'b1110, w, d, lat);
    n_rst = 1'b0;
    #2;
    check("arst_psi_req", psi_req, 0);
    check("arst_psi_data", psi_data, 0);
    check("arst_owner", owner, 0);
    check("arst_busy", busy, 0);
    check("arst_count", word_count, 0);
    check("arst_ack", src_ack, 0);
    n_rst = 1'b1;
    last_m = NR - 1;
    wc_m = 0;
    arb(4'b1111, w, d, lat);
    check("arst_first", w, 0);
    grant_word(w, d, 0);

    // Random traffic; word_count wraps past 2^CW.
    for (int k = 0; k < 14; k++) begin
      r = 4'($urandom_range(1, 15));
      arb(r, w, d, lat);
      check("rnd_latency", lat, 1);
      grant_word(w, d, $urandom_range(0, MW - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
